calcu16_loader: RTL and testbench

Serial program loader for the calcu16 core: receives a framed program image over an 8N1 UART line and writes each 26-bit instruction into instruction memory, from address 0 upward. It is the writer side of the instruction-memory interface the core reads from. It holds the core in a not-running state until a complete image with a valid checksum has landed. It sits between the board RX pin and the memory write port and drives the core's run enable.

---
 rtl/calcu16_pkg.sv | 18 +
 rtl/uart_rx_byte.sv | 88 ++++++++
 rtl/calcu16_loader.sv | 117 +++++++++++
 tb/tb_calcu16_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/calcu16_pkg.sv
// rtl/calcu16_pkg.sv - shared constants and loader state encoding for calcu16
package calcu16_pkg;

    localparam int INSTR_W = 26;
    localparam int ADDR_W  = 16;

    localparam logic [7:0] LOADER_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_WAIT_HDR,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_WORD,
        ST_CHKSUM,
        ST_RUN
    } loader_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with start-glitch rejection and stop check
module uart_rx_byte #(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_byte = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= '0;
                        state <= R_START;
                    end
                end
                R_START: begin
                    // a start bit that has gone high again by mid-bit is line noise
                    if (cnt == CW'(CLK_DIV / 2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    // returning to idle at mid-stop lets a back-to-back start edge be seen
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        cnt        <= '0;
                        byte_valid <= rx_s;
                        frame_err  <= !rx_s;
                        state      <= R_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/calcu16_loader.sv
// rtl/calcu16_loader.sv - framed UART program loader writing calcu16 instruction memory
module calcu16_loader
    import calcu16_pkg::*;
#(
    parameter int CLK_DIV = 104,
    parameter int INSTR_W = calcu16_pkg::INSTR_W,
    parameter int ADDR_W  = calcu16_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [0:INSTR_W-1] mem_wdata,
    output logic               core_run,
    output logic               load_err,
    output logic [ADDR_W-1:0]  words_loaded
);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_frame_err;

    loader_state_t state;
    logic [7:0]    count_hi;
    logic [15:0]   n_words;
    logic [1:0]    byte_idx;
    logic [23:0]   word_sh;
    logic [7:0]    csum;
    logic [31:0]   word_full;
    logic [ADDR_W-1:0] words_next;

    assign word_full  = {word_sh, rx_byte};
    assign words_next = words_loaded + 1'b1;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_WAIT_HDR;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_run     <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            count_hi     <= '0;
            n_words      <= '0;
            byte_idx     <= '0;
            word_sh      <= '0;
            csum         <= '0;
        end else begin
            mem_we <= 1'b0;
            // address advances the cycle after the strobe so it is stable during the write
            if (mem_we)
                mem_addr <= mem_addr + 1'b1;

            if (state != ST_RUN && rx_frame_err) begin
                load_err <= 1'b1;
                state    <= ST_WAIT_HDR;
            end else if (rx_valid) begin
                case (state)
                    ST_WAIT_HDR: begin
                        if (rx_byte == LOADER_HDR) begin
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            mem_addr     <= '0;
                            csum         <= '0;
                            byte_idx     <= '0;
                            state        <= ST_CNT_HI;
                        end
                    end
                    ST_CNT_HI: begin
                        count_hi <= rx_byte;
                        csum     <= csum ^ rx_byte;
                        state    <= ST_CNT_LO;
                    end
                    ST_CNT_LO: begin
                        n_words <= {count_hi, rx_byte};
                        csum    <= csum ^ rx_byte;
                        state   <= ({count_hi, rx_byte} == 16'd0) ? ST_CHKSUM : ST_WORD;
                    end
                    ST_WORD: begin
                        csum     <= csum ^ rx_byte;
                        byte_idx <= byte_idx + 1'b1;
                        word_sh  <= word_full[23:0];
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_wdata    <= word_full[INSTR_W-1:0];
                            words_loaded <= words_next;
                            if (words_next == ADDR_W'(n_words))
                                state <= ST_CHKSUM;
                        end
                    end
                    ST_CHKSUM: begin
                        if (rx_byte == csum) begin
                            core_run <= 1'b1;
                            state    <= ST_RUN;
                        end else begin
                            load_err <= 1'b1;
                            state    <= ST_WAIT_HDR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calcu16_loader.sv
// tb/tb_calcu16_loader.sv - scoreboard bench for calcu16_loader
module tb_calcu16_loader;

    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [0:25] mem_wdata;
    logic        core_run;
    logic        load_err;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [41:0] exp_q[$];
    logic [15:0] tb_addr;
    logic [7:0]  tb_csum;
    logic        prev_we = 1'b0;
    int          n_writes = 0;

    always #5 clk = ~clk;

    calcu16_loader #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_run     (core_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        logic [41:0] e;
        logic [25:0] d;
        if (rst_n && mem_we) begin
            n_writes++;
            check("we_back_to_back", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                d = mem_wdata;
                check("wr_addr", {16'd0, mem_addr}, {16'd0, e[41:26]});
                check("wr_data", {6'd0, d}, {6'd0, e[25:0]});
            end
        end
        prev_we = rst_n & mem_we;
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++)
            bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(8'hA5, 1'b1);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], 1'b1);
        tb_addr = 16'd0;
        tb_csum = n[15:8] ^ n[7:0];
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) begin
                exp_q.push_back({tb_addr, w[25:0]});
                tb_addr = tb_addr + 16'd1;
            end
            tb_csum = tb_csum ^ w[i*8 +: 8];
            send_byte(w[i*8 +: 8], 1'b1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        do_reset();
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", {6'd0, mem_wdata}, 32'd0);
        check("rst_run", {31'd0, core_run}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);

        // single word, literal checksum 2B
        send_hdr(16'd1);
        send_word(32'h0000002A);
        send_byte(8'h2B, 1'b1);
        repeat (4) @(negedge clk);
        check("single_run", {31'd0, core_run}, 32'd1);
        check("single_err", {31'd0, load_err}, 32'd0);
        check("single_words", {16'd0, words_loaded}, 32'd1);
        check("single_sb_empty", exp_q.size(), 32'd0);

        // RUN ignores a fresh frame
        n_writes = 0;
        send_hdr(16'd1);
        tb_addr = 16'd0;
        for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("run_no_writes", n_writes, 32'd0);
        check("run_stays", {31'd0, core_run}, 32'd1);

        // three words
        do_reset();
        send_hdr(16'd3);
        send_word(32'h03FFFFFF);
        send_word(32'h00000001);
        send_word(32'h01000000);
        send_byte(tb_csum, 1'b1);
        repeat (4) @(negedge clk);
        check("three_run", {31'd0, core_run}, 32'd1);
        check("three_words", {16'd0, words_loaded}, 32'd3);
        check("three_sb_empty", exp_q.size(), 32'd0);

        // bad checksum then recovery
        do_reset();
        send_hdr(16'd1);
        send_word(32'h0000002A);
        send_byte(8'h2C, 1'b1);
        repeat (4) @(negedge clk);
        check("badck_err", {31'd0, load_err}, 32'd1);
        check("badck_run", {31'd0, core_run}, 32'd0);
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        check("hdr_clears_err", {31'd0, load_err}, 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        tb_addr = 16'd0;
        tb_csum = 8'h01;
        send_word(32'h00000155);
        send_byte(tb_csum, 1'b1);
        repeat (4) @(negedge clk);
        check("recover_run", {31'd0, core_run}, 32'd1);

        // garbage, glitch and framing error
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("garbage_err", {31'd0, load_err}, 32'd0);
        send_hdr(16'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (2 * CLK_DIV) @(negedge clk);
        check("frame_err", {31'd0, load_err}, 32'd1);
        send_hdr(16'd0);
        send_byte(tb_csum, 1'b1);
        repeat (4) @(negedge clk);
        check("after_frame_run", {31'd0, core_run}, 32'd1);
        check("after_frame_err", {31'd0, load_err}, 32'd0);

        // empty image
        do_reset();
        n_writes = 0;
        send_hdr(16'd0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("empty_run", {31'd0, core_run}, 32'd1);
        check("empty_writes", n_writes, 32'd0);

        // reset during word 2 of 3
        do_reset();
        send_hdr(16'd3);
        send_word(32'h00ABCDEF);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_addr", {16'd0, mem_addr}, 32'd0);
        check("midrst_wdata", {6'd0, mem_wdata}, 32'd0);
        check("midrst_run", {31'd0, core_run}, 32'd0);
        check("midrst_words", {16'd0, words_loaded}, 32'd0);
        n_writes = 0;
        rst_n = 1'b1;
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        repeat (4) @(negedge clk);
        check("midrst_no_writes", n_writes, 32'd0);
        check("final_sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
